// File: rtl/enigma_host_driver.sv
// enigma_host_driver: FIFO-buffered initiator for the Enigma core's ready/data character handshake.
// Optional ENIGMA_HOST_DRIVER_FILTER_EN: uppercase a-z and drop non-letters at pop.
module enigma_host_driver #(
  parameter int FIFO_DEPTH = 8,
  parameter int READY_HOLD = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_wr_valid,
  input  logic [7:0] i_wr_data,
  output logic       o_wr_full,
  output logic       o_core_ready,
  output logic [7:0] o_core_data,
  input  logic       i_core_ready,
  input  logic [7:0] i_core_data,
  output logic       o_rd_valid,
  output logic [7:0] o_rd_data,
  input  logic       i_rd_ack,
  output logic       o_busy,
  output logic       o_timeout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(READY_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_WAIT, S_DELIVER} state_e;
  state_e         state_q, state_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           prev_rdy_q, got_q, got_d, core_ready_q, core_ready_d;
  logic           rd_valid_q, rd_valid_d, timeout_q, timeout_d;
  logic [7:0]     got_data_q, got_data_d, core_data_q, core_data_d, rd_data_q, rd_data_d;
  logic           wr_ok, pop, rise, fwd;
  logic [7:0]     head, byte_f;
  always_comb begin
    wr_ok = i_wr_valid && (count_q < CW'(FIFO_DEPTH));
    head = mem_q[rd_ptr_q];
`ifdef ENIGMA_HOST_DRIVER_FILTER_EN
    byte_f = (head >= "a" && head <= "z") ? head - 8'd32 : head;
    fwd = byte_f >= "A" && byte_f <= "Z";
`else
    byte_f = head;
    fwd = 1'b1;
`endif
    rise = i_core_ready & ~prev_rdy_q;
    pop = 1'b0;
    state_d = state_q;
    hold_d = hold_q;
    tmo_d = tmo_q;
    got_d = got_q;
    got_data_d = got_data_q;
    core_ready_d = core_ready_q;
    core_data_d = core_data_q;
    rd_valid_d = rd_valid_q;
    rd_data_d = rd_data_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        pop = 1'b1;
        if (fwd) begin
          core_data_d = byte_f;
          core_ready_d = 1'b1;
          hold_d = HW'(READY_HOLD - 1);
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (rise) begin
          got_d = 1'b1;
          got_data_d = i_core_data;
        end
        if (hold_q == '0) begin
          core_ready_d = 1'b0;
          tmo_d = TW'(TIMEOUT - 1);
          state_d = S_WAIT;
        end else hold_d = hold_q - 1'b1;
      end
      S_WAIT: if (got_q || rise) begin
        rd_data_d = got_q ? got_data_q : i_core_data;
        rd_valid_d = 1'b1;
        got_d = 1'b0;
        state_d = S_DELIVER;
      end else if (tmo_q == '0) begin
        timeout_d = 1'b1;
        state_d = S_IDLE;
      end else tmo_d = tmo_q - 1'b1;
      S_DELIVER: if (i_rd_ack) begin
        rd_valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(wr_ok) - CW'(pop);
  end
  always_ff @(posedge i_clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      hold_q <= '0;
      tmo_q <= '0;
      prev_rdy_q <= 1'b0;
      got_q <= 1'b0;
      got_data_q <= 8'h00;
      core_ready_q <= 1'b0;
      core_data_q <= 8'h00;
      rd_valid_q <= 1'b0;
      rd_data_q <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      hold_q <= hold_d;
      tmo_q <= tmo_d;
      prev_rdy_q <= i_core_ready;
      got_q <= got_d;
      got_data_q <= got_data_d;
      core_ready_q <= core_ready_d;
      core_data_q <= core_data_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_wr_full = count_q == CW'(FIFO_DEPTH);
  assign o_core_ready = core_ready_q;
  assign o_core_data = core_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data = rd_data_q;
  assign o_busy = state_q != S_IDLE || count_q != '0;
  assign o_timeout = timeout_q;
endmodule
